// File: rtl/instr_fetch_pkg.sv
// Shared constants for the fetch stage: default widths, reset PC, buffer depth
// and the NOP presented to decode when no instruction is available.
package instr_fetch_pkg;

  localparam int unsigned INST_WIDTH_DEF   = 32;
  localparam int unsigned ADDR_WIDTH_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;
  localparam int unsigned FETCH_FIFO_DEPTH = 4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, instruction} entries with flush.
// Head data is read straight from the storage registers.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues in-order word fetches under a credit limit, buffers tagged
// responses for decode, and on redirect flushes and drops in-flight responses.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned           INST_WIDTH = INST_WIDTH_DEF,
  parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
  parameter int unsigned           FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic                  misalign_err
);

  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam int unsigned EW = ADDR_WIDTH + INST_WIDTH;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [INST_WIDTH-1:0] NOP_C = INST_WIDTH'(NOP_INST);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic                  misalign_q, misalign_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_rdata;
  logic [CW:0]           credit_used;
  logic [ADDR_WIDTH-1:0] target_pc;
  logic                  accept, push, pop;

  // Buffered plus in-flight fetches never exceed the buffer size, so a
  // response always has a free slot waiting for it.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req    = ~reset & ~redirect & (credit_used < DEPTH_C);
  assign imem_addr   = fetch_pc_q;

  assign inst_valid   = ~fifo_empty;
  assign inst         = inst_valid ? fifo_rdata[INST_WIDTH-1:0] : NOP_C;
  assign inst_pc      = inst_valid ? fifo_rdata[EW-1:INST_WIDTH] : '0;
  assign misalign_err = misalign_q;

  always_comb begin
    target_pc     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    accept        = imem_req & imem_ready;
    push          = imem_rvalid & ~redirect & (drop_cnt_q == '0);
    pop           = inst_valid & inst_ready;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    misalign_d    = misalign_q;
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      // No request is accepted this cycle, so whatever remains in flight after
      // it belongs to the old path.
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
      misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
      end
      if (imem_rvalid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      misalign_q    <= misalign_d;
      assert (!(push && fifo_full && !pop));
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({resp_pc_q, imem_rdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
